// File: rtl/result_collector.sv
// Collects encrypter results in strict dispatch order and serialises each word as LSB-first nibbles.
// Optional watchdog in WAIT enabled by defining COLLECTOR_TIMEOUT_EN.
module result_collector #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_ENCRYPTERS-1:0]                 enc_result_valid,
  input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_result_data,
  output logic [NUM_ENCRYPTERS-1:0]                 enc_result_ack,
  input  logic                                      flush,
  output logic [3:0]                                out_nibble,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [$clog2(NUM_ENCRYPTERS)-1:0]         expected_index,
  output logic                                      busy,
  output logic                                      timeout_err
);

  localparam int IDX_W   = $clog2(NUM_ENCRYPTERS);
  localparam int NIBBLES = ENCRYPTER_WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;

  function automatic logic [NUM_ENCRYPTERS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_ENCRYPTERS-1:0] one;
    one      = '0;
    one[idx] = 1'b1;
    return one;
  endfunction

  logic [1:0]                 state_r;
  logic [IDX_W-1:0]           idx_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [ENCRYPTER_WIDTH-1:0] word_r;
  logic [NUM_ENCRYPTERS-1:0]  ack_r;
  logic [3:0]                 out_nibble_r;
  logic                       out_valid_r;
  logic                       busy_r;

  logic                       take_s;
  logic                       xfer_s;
  logic                       wd_fire_s;
  logic [ENCRYPTER_WIDTH-1:0] cand_s;
  logic [ENCRYPTER_WIDTH-1:0] word_sh_s;

  assign take_s    = (state_r == ST_WAIT) && enc_result_valid[idx_r];
  assign xfer_s    = out_valid_r && out_ready;
  assign cand_s    = enc_result_data[idx_r*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
  assign word_sh_s = word_r >> 3'd4;

`ifdef COLLECTOR_TIMEOUT_EN
  logic [7:0] wd_r;
  logic       timeout_err_r;

  assign wd_fire_s = (state_r == ST_WAIT) && !take_s && (wd_r == 8'hFF);

  // Watchdog: counts idle WAIT cycles, flags a stalled encrypter and skips it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r          <= 8'd0;
      timeout_err_r <= 1'b0;
    end else if (flush || (state_r != ST_WAIT) || take_s) begin
      wd_r <= 8'd0;
    end else if (wd_fire_s) begin
      wd_r          <= 8'd0;
      timeout_err_r <= 1'b1;
    end else begin
      wd_r <= wd_r + 8'd1;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign wd_fire_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main collection FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_WAIT;
      idx_r        <= '0;
      cnt_r        <= '0;
      word_r       <= '0;
      ack_r        <= '0;
      out_nibble_r <= 4'd0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else if (flush) begin
      state_r      <= ST_WAIT;
      idx_r        <= '0;
      cnt_r        <= '0;
      ack_r        <= '0;
      out_nibble_r <= 4'd0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (take_s) begin
            word_r  <= cand_s;
            ack_r   <= idx_onehot(idx_r);
            state_r <= ST_CAPTURE;
            busy_r  <= 1'b1;
          end else if (wd_fire_s) begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_CAPTURE: begin
          ack_r        <= '0;
          cnt_r        <= '0;
          out_valid_r  <= 1'b1;
          out_nibble_r <= word_r[3:0];
          state_r      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (xfer_s) begin
            if (cnt_r == LAST_NIB) begin
              out_valid_r <= 1'b0;
              idx_r       <= idx_r + 1'b1;
              state_r     <= ST_WAIT;
              busy_r      <= 1'b0;
            end else begin
              // Shift so the next nibble is always at the bottom of word_r.
              cnt_r        <= cnt_r + 1'b1;
              word_r       <= word_sh_s;
              out_nibble_r <= word_sh_s[3:0];
            end
          end
        end
        default: begin
          state_r     <= ST_WAIT;
          ack_r       <= '0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // A flush during CAPTURE withdraws the ack so the encrypter keeps its result.
  assign enc_result_ack = ack_r & ~{NUM_ENCRYPTERS{flush}};
  assign out_nibble     = out_nibble_r;
  assign out_valid      = out_valid_r;
  assign expected_index = idx_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (4 encrypters, 32-bit words).
module tb_result_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   valid;
  logic [127:0] data;
  logic [3:0]   ack;
  logic         flush;
  logic [3:0]   out_nibble;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   expected_index;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  result_collector #(.NUM_ENCRYPTERS(4), .ENCRYPTER_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .enc_result_valid(valid), .enc_result_data(data), .enc_result_ack(ack),
    .flush(flush), .out_nibble(out_nibble), .out_valid(out_valid), .out_ready(out_ready),
    .expected_index(expected_index), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 4'd0; data = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({ack, out_valid, out_nibble, busy, timeout_err, expected_index} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got ack=%b ov=%b nib=%h busy=%b terr=%b idx=%0d expected all zero",
               ack, out_valid, out_nibble, busy, timeout_err, expected_index);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Drives one word through capture and 8 nibble transfers with out_ready high.
  task automatic collect_word(input logic [1:0] idx, input logic [31:0] word);
    logic [3:0] exp_nib;
    checks++;
    if (expected_index !== idx) begin
      errors++;
      $display("FAIL start_index got %0d expected %0d", expected_index, idx);
    end
    valid[idx] = 1'b1;
    data[idx*32 +: 32] = word;
    out_ready = 1'b1;
    tick();
    checks++;
    if (ack !== (4'b0001 << idx) || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL capture_ack got ack=%b ov=%b busy=%b expected ack=%b ov=0 busy=1",
               ack, out_valid, busy, 4'b0001 << idx);
    end
    tick();
    valid[idx] = 1'b0;
    data[idx*32 +: 32] = ~word;
    for (int k = 0; k < 8; k++) begin
      exp_nib = word[4*k +: 4];
      checks++;
      if (out_valid !== 1'b1 || out_nibble !== exp_nib || ack !== 4'd0) begin
        errors++;
        $display("FAIL nibble_%0d got ov=%b nib=%h ack=%b expected ov=1 nib=%h ack=0000",
                 k, out_valid, out_nibble, ack, exp_nib);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || expected_index !== idx + 2'd1) begin
      errors++;
      $display("FAIL word_done got ov=%b busy=%b idx=%0d expected ov=0 busy=0 idx=%0d",
               out_valid, busy, expected_index, idx + 2'd1);
    end
  endtask

  task automatic test_basic();
    collect_word(2'd0, 32'h87654321);
  endtask

  task automatic test_order();
    valid[2] = 1'b1;
    data[64 +: 32] = 32'h22222222;
    collect_word(2'd1, 32'h11111111);
    collect_word(2'd2, 32'h22222222);
  endtask

  task automatic test_stall();
    int xfers;
    logic [3:0] exp_nib;
    valid[3] = 1'b1;
    data[96 +: 32] = 32'hA5A5A5A5;
    out_ready = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b1000) begin
      errors++;
      $display("FAIL stall_ack got %b expected 1000", ack);
    end
    tick();
    valid[3] = 1'b0;
    xfers = 0;
    for (int cyc = 0; cyc < 40 && out_valid; cyc++) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      exp_nib = (xfers % 2 == 0) ? 4'h5 : 4'hA;
      checks++;
      if (out_nibble !== exp_nib) begin
        errors++;
        $display("FAIL stall_nibble cyc %0d got %h expected %h", cyc, out_nibble, exp_nib);
      end
      if (out_ready) xfers++;
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (xfers != 8 || out_valid !== 1'b0 || expected_index !== 2'd0) begin
      errors++;
      $display("FAIL stall_done got xfers=%0d ov=%b idx=%0d expected 8 0 0", xfers, out_valid, expected_index);
    end
  endtask

  task automatic test_back_to_back();
    collect_word(2'd0, 32'h01234567);
    collect_word(2'd1, 32'h89ABCDEF);
    collect_word(2'd2, 32'hFEDCBA98);
    collect_word(2'd3, 32'h76543210);
    collect_word(2'd0, 32'h0F1E2D3C);
  endtask

  task automatic test_flush();
    valid[1] = 1'b1;
    data[32 +: 32] = 32'h89ABCDEF;
    tick();
    tick();
    valid[1] = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (out_nibble !== 4'hC || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush got nib=%h ov=%b expected C 1", out_nibble, out_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || expected_index !== 2'd0 || busy !== 1'b0 || ack !== 4'd0) begin
      errors++;
      $display("FAIL flush_shift got ov=%b idx=%0d busy=%b ack=%b expected 0 0 0 0000",
               out_valid, expected_index, busy, ack);
    end
    valid[0] = 1'b1;
    data[0 +: 32] = 32'h13579BDF;
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (ack !== 4'd0) begin
      errors++;
      $display("FAIL flush_capture_ack got %b expected 0000", ack);
    end
    tick();
    flush = 1'b0;
    valid[0] = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || expected_index !== 2'd0) begin
      errors++;
      $display("FAIL flush_capture_state got busy=%b ov=%b idx=%0d expected 0 0 0", busy, out_valid, expected_index);
    end
  endtask

  task automatic test_async_reset();
    valid[0] = 1'b1;
    data[0 +: 32] = 32'h9999AAAA;
    tick();
    tick();
    valid[0] = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_nibble !== 4'hA) begin
      errors++;
      $display("FAIL pre_reset got ov=%b busy=%b nib=%h expected 1 1 A", out_valid, busy, out_nibble);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_nibble !== 4'd0 || ack !== 4'd0 || expected_index !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got ov=%b busy=%b nib=%h ack=%b idx=%0d expected all zero",
               out_valid, busy, out_nibble, ack, expected_index);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 300 && !timeout_err; i++) tick();
`ifdef COLLECTOR_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b1 || expected_index !== 2'd1 || ack !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout got terr=%b idx=%0d ack=%b ov=%b expected 1 1 0000 0",
               timeout_err, expected_index, ack, out_valid);
    end
`else
    checks++;
    if (timeout_err !== 1'b0 || expected_index !== 2'd0) begin
      errors++;
      $display("FAIL no_timeout got terr=%b idx=%0d expected 0 0", timeout_err, expected_index);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter NUM_ENCRYPTERS, default 4: number of encrypter result ports (power of two, 2..16).
REQ-002 SHALL have parameter ENCRYPTER_WIDTH, default 32: result word width (multiple of 4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enc_result_valid  input  NUM_ENCRYPTERS  per-encrypter result-available flag, held until acked.
REQ-006 SHALL have port enc_result_data  input  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened results, encrypter i at bits [i*W +: W].
REQ-007 SHALL have port enc_result_ack  output  NUM_ENCRYPTERS  one-cycle pulse, result of encrypter i consumed.
REQ-008 SHALL have port flush  input  1  synchronous abort; restart ordering at encrypter 0.
REQ-009 SHALL have port out_nibble  output  4  serialized result nibble.
REQ-010 SHALL have port out_valid  output  1  out_nibble valid.
REQ-011 SHALL have port out_ready  input  1  downstream QSPI sink accepts nibble.
REQ-012 SHALL have port expected_index  output  log2(NUM_ENCRYPTERS)  next encrypter to be collected.
REQ-013 SHALL have port busy  output  1  high whenever state is not WAIT.
REQ-014 SHALL have port timeout_err  output  1  sticky watchdog flag (see Configuration).

Function
REQ-015 SHALL collect results strictly in dispatch order 0,1,..,NUM_ENCRYPTERS-1, wrapping to 0; valids from other indices ignored.
REQ-016 SHALL implement FSM states WAIT, CAPTURE, SHIFT.
REQ-017 WAIT: when enc_result_valid[expected_index]=1 at edge t, SHALL register that word and go CAPTURE.
REQ-018 CAPTURE: SHALL drive enc_result_ack[expected_index]=1 for exactly this one cycle (t+1), all other ack bits 0, then go SHIFT.
REQ-019 SHALL accept that the encrypter drops valid the cycle after the ack edge.
REQ-020 SHIFT: SHALL assert out_valid with nibble k = word bits [4k+3:4k], k from 0 (LSB nibble first), from cycle t+2.
REQ-021 SHALL advance k only on a cycle with out_valid & out_ready; out_nibble stable while out_ready=0.
REQ-022 After nibble ENCRYPTER_WIDTH/4-1 transfers, SHALL deassert out_valid next cycle, increment expected_index modulo NUM_ENCRYPTERS, return to WAIT.
REQ-023 Minimum per-word period SHALL be ENCRYPTER_WIDTH/4+2 cycles with out_ready held high.
REQ-024 flush=1 SHALL, next edge, force WAIT, expected_index=0, nibble count 0, out_valid=0, acks 0; flush wins over all simultaneous events; a nibble handshaken in the flush cycle counts as delivered downstream only.
REQ-025 flush in CAPTURE SHALL suppress the pending ack.
REQ-026 Changes on enc_result_data after capture SHALL not affect the word in SHIFT.

Reset
REQ-027 reset=0 SHALL immediately force WAIT, expected_index=0, enc_result_ack=0, out_valid=0, out_nibble=0, busy=0, timeout_err=0, watchdog=0, independent of clk.
REQ-028 Reset release SHALL take effect at the first rising clk edge with reset=1; no capture on that edge's prior state.

Configuration
REQ-029 Macro COLLECTOR_TIMEOUT_EN SHALL enable an 8-bit watchdog counting cycles spent in WAIT.
REQ-030 With the macro, SHALL at count 255 without expected valid set timeout_err=1 (sticky until reset), advance expected_index by one, clear count; no ack, no output.
REQ-031 With the macro, count SHALL clear on leaving WAIT and on flush.
REQ-032 Without the macro, SHALL wait indefinitely; timeout_err tied 0; no watchdog logic.

Verification (NUM_ENCRYPTERS=4, ENCRYPTER_WIDTH=32)
REQ-033 Valid[0] with 0x87654321, out_ready=1 -> ack[0] pulse one cycle, nibbles 1,2,3,4,5,6,7,8 on 8 consecutive cycles, expected_index 0->1.
REQ-034 Valid[2] and valid[1] both held, expected_index=1 -> encrypter 1 acked/output first, then 2; ack[2] never before 1's last nibble.
REQ-035 out_ready toggled 1,0,0,1.. during 0xA5A5A5A5 -> exactly 8 transfers, out_nibble stable during stalls, order 5,A,5,A,5,A,5,A.
REQ-036 Four words, out_ready=1 -> expected_index 0,1,2,3,0; fifth word from encrypter 0 collected.
REQ-037 flush mid-SHIFT after 3 nibbles -> next cycle out_valid=0, expected_index=0; reset=0 asserted mid-SHIFT -> outputs zero before next clk edge.
REQ-038 COLLECTOR_TIMEOUT_EN defined, no valid for 255 cycles -> timeout_err=1, expected_index 0->1; undefined -> index stays 0.
